// File: rtl/comp_pipe.sv
// Two-stage magnitude comparator with valid/ready flow control and
// saturating per-outcome result counters.
module comp_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_ls_b,
  output logic             a_eq_b,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] ls_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  input  logic             clr_cnt
);

  logic             advance_s;
  logic             out_xfer_s;
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             out_valid_q;
  logic             gt_q, ls_q, eq_q;
  logic             gt_d, ls_d, eq_d;
  logic [WIDTH-1:0] a_cmp_s;
  logic [WIDTH-1:0] b_cmp_s;
  logic [CNT_W-1:0] gt_cnt_q, ls_cnt_q, eq_cnt_q;
  logic [CNT_W-1:0] gt_cnt_d, ls_cnt_d, eq_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  assign advance_s  = !out_valid_q || out_ready;
  assign out_xfer_s = out_valid_q && out_ready;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_cmp_s = a_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
    b_cmp_s = b_q ^ {sgn_q, {(WIDTH-1){1'b0}}};
    gt_d    = s1_valid_q && (a_cmp_s > b_cmp_s);
    ls_d    = s1_valid_q && (a_cmp_s < b_cmp_s);
    eq_d    = s1_valid_q && (a_q == b_q);
  end

  // Count only the outcome of the result leaving this cycle.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    ls_cnt_d = ls_cnt_q;
    eq_cnt_d = eq_cnt_q;
    if (out_xfer_s) begin
      if (gt_q) begin
        gt_cnt_d = sat_inc(gt_cnt_q);
      end else if (ls_q) begin
        ls_cnt_d = sat_inc(ls_cnt_q);
      end else if (eq_q) begin
        eq_cnt_d = sat_inc(eq_cnt_q);
      end else begin
        gt_cnt_d = gt_cnt_q;
      end
    end else begin
      gt_cnt_d = gt_cnt_q;
    end
  end

  // Operand registers carry no reset; they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= sgn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      ls_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else if (advance_s) begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      gt_q        <= gt_d;
      ls_q        <= ls_d;
      eq_q        <= eq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      gt_cnt_q <= {CNT_W{1'b0}};
      ls_cnt_q <= {CNT_W{1'b0}};
      eq_cnt_q <= {CNT_W{1'b0}};
    end else begin
      gt_cnt_q <= gt_cnt_d;
      ls_cnt_q <= ls_cnt_d;
      eq_cnt_q <= eq_cnt_d;
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = out_valid_q;
  assign a_gt_b    = gt_q;
  assign a_ls_b    = ls_q;
  assign a_eq_b    = eq_q;
  assign gt_cnt    = gt_cnt_q;
  assign ls_cnt    = ls_cnt_q;
  assign eq_cnt    = eq_cnt_q;

endmodule
